v_regfile_sb: RTL and testbench
===============================

# v_regfile_sb

Vector register file with integrated busy-bit scoreboard. It is the receiving end of the vector writeback interface (`vwb_en`/`vwb_addr`/`vwb_data`):

- It commits writeback results into 32 × `VREG_DW`-bit registers.
- It serves two registered read ports to vector decode/execute.
- It tracks in-flight destinations so issue can stall on read-after-write (RAW) and write-after-write (WAW) hazards.

It sits between the vector writeback stage and the vector issue/decode stage.

## Interface
Parameters:
- `VREG_DW`, default 256: vector register width in bits.
- `VREG_AW`, default 5: register address width; depth is 2^`VREG_AW`.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-low.
- `vwb_en_i`  input  1  writeback commit strobe.
- `vwb_addr_i`  input  `VREG_AW`  writeback destination register.
- `vwb_data_i`  input  `VREG_DW`  writeback data.
- `vrd_en_i`  input  1  read request for both read ports.
- `vrs1_addr_i`  input  `VREG_AW`  read port 1 address.
- `vrs2_addr_i`  input  `VREG_AW`  read port 2 address.
- `vrs1_data_o`  output  `VREG_DW`  read port 1 data, registered.
- `vrs2_data_o`  output  `VREG_DW`  read port 2 data, registered.
- `vrs1_busy_o`  output  1  source 1 has a pending write; combinational.
- `vrs2_busy_o`  output  1  source 2 has a pending write; combinational.
- `vissue_en_i`  input  1  issue request claiming a destination.
- `vissue_addr_i`  input  `VREG_AW`  destination being claimed.
- `vstall_o`  output  1  issue refused (WAW on a busy destination); combinational.

## Operation
- **Storage.** `regs[0..2^VREG_AW-1]` holds `VREG_DW` bits each. All registers, including register 0, are writable.
- **Write.**
  - When `vwb_en_i` is high at a rising edge, `regs[vwb_addr_i]` ← `vwb_data_i`.
  - The same edge clears `busy[vwb_addr_i]`.
- **Read.**
  - When `vrd_en_i` is high at a rising edge, `vrs1_data_o` ← `regs[vrs1_addr_i]` and `vrs2_data_o` ← `regs[vrs2_addr_i]`.
  - When `vrd_en_i` is low, both outputs hold their previous value.
- **Busy flags.** `vrs1_busy_o` = `busy[vrs1_addr_i]` and `vrs2_busy_o` = `busy[vrs2_addr_i]`. These flags are independent of `vrd_en_i`.
- **Stall.** `vstall_o` = `vissue_en_i` & `busy[vissue_addr_i]`, evaluated after the same-cycle writeback clear (see below).
- **Issue accept.** An issue is accepted when `vissue_en_i` is high and `vstall_o` is low. An accepted issue sets `busy[vissue_addr_i]` at the edge.
- **Same-cycle writeback and issue:**
  - Different addresses: the writeback address is cleared and the issue address is set.
  - Same address, destination currently busy: the writeback clear is seen by stall evaluation, so `vstall_o` = 0. The issue is accepted and the busy bit ends set (the new owner).
- **Writeback to a non-busy register.** Data is written and the busy bit stays 0. This is legal.
- **Reset** (`rst` = 0 at an edge):
  - All busy bits clear, all registers clear to 0, and `vrs1_data_o`/`vrs2_data_o` go to 0.
  - Writes, reads and issues presented in the same cycle are dropped.
  - Combinational outputs read 0 whenever busy is all-clear.

## Timing
- Read latency is 1 cycle: an address presented in cycle N gives data in cycle N+1.
- A write in cycle N is visible to a read issued in cycle N+1 or later (data in N+2).
- A read in the same cycle as a write to the same address follows the Configuration section.
- A busy bit set by an issue at the edge ending cycle N is visible on `vrs*_busy_o` and `vstall_o` from cycle N+1.
- No handshake back to writeback: every `vwb_en_i` is accepted unconditionally, one write per cycle.

## Configuration
- `V_REGFILE_BYPASS_EN` defined:
  - A read in cycle N whose address equals `vwb_addr_i` with `vwb_en_i` high returns `vwb_data_i` in N+1. This applies to both ports independently.
  - `vrs*_busy_o` is forced 0 for a source matching a same-cycle writeback address.
- Not defined:
  - That read returns the pre-write value.
  - `vrs*_busy_o` reflects the stored busy bit, so a consumer must wait one more cycle.

## Test plan
- **Reset then read:** drop `rst` mid-traffic for 1 cycle, then read v0 and v31 -> `vrs1_data_o` = `vrs2_data_o` = 0, all busy = 0, `vstall_o` = 0.
- **Write/read:** write v5 = {8{32'hDEADBEEF}} in cycle 1, read v5 on port 2 in cycle 2 -> `vrs2_data_o` = that value in cycle 3.
- **Same-cycle collision:** write v7 = 256'h1 while reading v7 on port 1, with v7 previously 0 -> port 1 returns 256'h1 with `V_REGFILE_BYPASS_EN`, and 0 without it.
- **Scoreboard:**
  - Issue v3, then present `vrs1_addr_i` = 3 -> `vrs1_busy_o` = 1.
  - Re-issue v3 -> `vstall_o` = 1 and busy unchanged.
  - Writeback v3 -> busy = 0 next cycle.
- **Simultaneous writeback and issue:**
  - Writeback v9 and issue v9 in the same cycle with v9 busy -> `vstall_o` = 0 and `busy[9]` = 1 afterwards.
  - Writeback v9 and issue v10 in the same cycle -> `busy[9]` = 0 and `busy[10]` = 1.
- **Back-to-back writes:** write v1..v31 on consecutive cycles, then read all pairs -> every register returns its written value, with no write lost.

Source files
------------

// File: rtl/v_regfile_sb_if.sv
// Vector regfile bus: writeback commit, dual read request/response,
// per-source busy flags and the issue claim/stall pair.
// master = writeback/issue/decode side, slave = the register file.
interface v_regfile_sb_if #(
  parameter int VREG_DW = 256,
  parameter int VREG_AW = 5
);
  logic               vwb_en_i;
  logic [VREG_AW-1:0] vwb_addr_i;
  logic [VREG_DW-1:0] vwb_data_i;
  logic               vrd_en_i;
  logic [VREG_AW-1:0] vrs1_addr_i;
  logic [VREG_AW-1:0] vrs2_addr_i;
  logic [VREG_DW-1:0] vrs1_data_o;
  logic [VREG_DW-1:0] vrs2_data_o;
  logic               vrs1_busy_o;
  logic               vrs2_busy_o;
  logic               vissue_en_i;
  logic [VREG_AW-1:0] vissue_addr_i;
  logic               vstall_o;

  modport master (
    output vwb_en_i, vwb_addr_i, vwb_data_i,
    output vrd_en_i, vrs1_addr_i, vrs2_addr_i,
    output vissue_en_i, vissue_addr_i,
    input  vrs1_data_o, vrs2_data_o, vrs1_busy_o, vrs2_busy_o, vstall_o
  );

  modport slave (
    input  vwb_en_i, vwb_addr_i, vwb_data_i,
    input  vrd_en_i, vrs1_addr_i, vrs2_addr_i,
    input  vissue_en_i, vissue_addr_i,
    output vrs1_data_o, vrs2_data_o, vrs1_busy_o, vrs2_busy_o, vstall_o
  );
endinterface

// File: rtl/v_regfile_sb.sv
// Vector register file with busy-bit scoreboard.
// 2^VREG_AW registers of VREG_DW bits, one writeback port, two registered
// read ports, and a busy bit per register claimed by issue and released by
// writeback. Synchronous active-low reset clears data, busy bits and outputs.
// Optional feature: define V_REGFILE_BYPASS_EN to forward same-cycle
// writeback data to the read ports and mask the matching busy flags.
module v_regfile_sb #(
  parameter int VREG_DW = 256,
  parameter int VREG_AW = 5
) (
  input logic           clk,
  input logic           rst,
  v_regfile_sb_if.slave bus
);
  localparam int Depth = 1 << VREG_AW;

  logic [VREG_DW-1:0] regs_q [Depth];
  logic [Depth-1:0]   busy_q;
  logic [Depth-1:0]   busy_d;
  logic [Depth-1:0]   busyAfterWb;
  logic               issueAccept;
  logic [VREG_DW-1:0] vrs1_data_q;
  logic [VREG_DW-1:0] vrs1_data_d;
  logic [VREG_DW-1:0] vrs2_data_q;
  logic [VREG_DW-1:0] vrs2_data_d;
  logic [VREG_DW-1:0] rd1Val;
  logic [VREG_DW-1:0] rd2Val;
  logic               busy1;
  logic               busy2;

  // Scoreboard next state: writeback releases first, so an issue to the
  // register being written back in the same cycle sees it free and claims it.
  always_comb begin
    busyAfterWb = busy_q;
    if (bus.vwb_en_i) busyAfterWb[bus.vwb_addr_i] = 1'b0;
    issueAccept = bus.vissue_en_i & ~busyAfterWb[bus.vissue_addr_i];
    busy_d = busyAfterWb;
    if (issueAccept) busy_d[bus.vissue_addr_i] = 1'b1;
  end

  assign bus.vstall_o = bus.vissue_en_i & busyAfterWb[bus.vissue_addr_i];

`ifdef V_REGFILE_BYPASS_EN
  logic wbHit1;
  logic wbHit2;

  // Forward writeback data to a matching read and hide its busy flag.
  always_comb begin
    wbHit1 = bus.vwb_en_i && (bus.vwb_addr_i == bus.vrs1_addr_i);
    wbHit2 = bus.vwb_en_i && (bus.vwb_addr_i == bus.vrs2_addr_i);
    rd1Val = wbHit1 ? bus.vwb_data_i : regs_q[bus.vrs1_addr_i];
    rd2Val = wbHit2 ? bus.vwb_data_i : regs_q[bus.vrs2_addr_i];
    busy1  = busy_q[bus.vrs1_addr_i] & ~wbHit1;
    busy2  = busy_q[bus.vrs2_addr_i] & ~wbHit2;
  end
`else
  // Reads see the stored array only; a same-cycle write lands after the read.
  always_comb begin
    rd1Val = regs_q[bus.vrs1_addr_i];
    rd2Val = regs_q[bus.vrs2_addr_i];
    busy1  = busy_q[bus.vrs1_addr_i];
    busy2  = busy_q[bus.vrs2_addr_i];
  end
`endif

  assign bus.vrs1_busy_o = busy1;
  assign bus.vrs2_busy_o = busy2;

  // Read ports capture on a read request and otherwise hold.
  always_comb begin
    vrs1_data_d = vrs1_data_q;
    vrs2_data_d = vrs2_data_q;
    if (bus.vrd_en_i) begin
      vrs1_data_d = rd1Val;
      vrs2_data_d = rd2Val;
    end
  end

  // Read data and busy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vrs1_data_q <= '0;
      vrs2_data_q <= '0;
      busy_q      <= '0;
    end else begin
      vrs1_data_q <= vrs1_data_d;
      vrs2_data_q <= vrs2_data_d;
      busy_q      <= busy_d;
    end
  end

  // Register array: every entry, including 0, is writable and cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else if (bus.vwb_en_i) begin
      regs_q[bus.vwb_addr_i] <= bus.vwb_data_i;
    end
  end

  assign bus.vrs1_data_o = vrs1_data_q;
  assign bus.vrs2_data_o = vrs2_data_q;
endmodule

// File: tb/tb_v_regfile_sb.sv
// Self-checking bench for v_regfile_sb: a reference model of the array and
// scoreboard predicts busy/stall each cycle and queues expected read data,
// which is popped when the registered read ports update.
module tb_v_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [255:0] d1;
    logic [255:0] d2;
  } rdExp_t;

  rdExp_t       expQ[$];
  logic [255:0] modelRegs [32];
  logic [31:0]  modelBusy;

  v_regfile_sb_if #(.VREG_DW(256), .VREG_AW(5)) bus ();

  v_regfile_sb #(.VREG_DW(256), .VREG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Keep the run bounded even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive one cycle, check combinational flags, update the model, then
  // compare any read result that the edge produced.
  task automatic applyStimulus(input logic wbEn, input logic [4:0] wbAddr, input logic [255:0] wbData,
                               input logic rdEn, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic issEn, input logic [4:0] issAddr);
    logic [31:0] clr;
    logic        expStall;
    logic        expB1;
    logic        expB2;
    rdExp_t      e;
    @(negedge clk);
    bus.vwb_en_i      = wbEn;
    bus.vwb_addr_i    = wbAddr;
    bus.vwb_data_i    = wbData;
    bus.vrd_en_i      = rdEn;
    bus.vrs1_addr_i   = rs1;
    bus.vrs2_addr_i   = rs2;
    bus.vissue_en_i   = issEn;
    bus.vissue_addr_i = issAddr;
    #1;
    clr = modelBusy;
    if (wbEn) clr[wbAddr] = 1'b0;
    expStall = issEn & clr[issAddr];
    expB1 = modelBusy[rs1];
    expB2 = modelBusy[rs2];
`ifdef V_REGFILE_BYPASS_EN
    if (wbEn && wbAddr == rs1) expB1 = 1'b0;
    if (wbEn && wbAddr == rs2) expB2 = 1'b0;
`endif
    checkOutput("busy1", 256'(bus.vrs1_busy_o), 256'(expB1));
    checkOutput("busy2", 256'(bus.vrs2_busy_o), 256'(expB2));
    checkOutput("stall", 256'(bus.vstall_o), 256'(expStall));
    if (!rst) begin
      e.d1 = '0;
      e.d2 = '0;
      expQ.push_back(e);
      for (int i = 0; i < 32; i++) modelRegs[i] = '0;
      modelBusy = '0;
    end else begin
      if (rdEn) begin
        e.d1 = modelRegs[rs1];
        e.d2 = modelRegs[rs2];
`ifdef V_REGFILE_BYPASS_EN
        if (wbEn && wbAddr == rs1) e.d1 = wbData;
        if (wbEn && wbAddr == rs2) e.d2 = wbData;
`endif
        expQ.push_back(e);
      end
      if (wbEn) modelRegs[wbAddr] = wbData;
      modelBusy = clr;
      if (issEn && !expStall) modelBusy[issAddr] = 1'b1;
    end
    @(posedge clk);
    #1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rd1", bus.vrs1_data_o, e.d1);
      checkOutput("rd2", bus.vrs2_data_o, e.d2);
    end
  endtask

  initial begin
    logic [255:0] rdata;
    bus.vwb_en_i      = 1'b0;
    bus.vwb_addr_i    = '0;
    bus.vwb_data_i    = '0;
    bus.vrd_en_i      = 1'b0;
    bus.vrs1_addr_i   = '0;
    bus.vrs2_addr_i   = '0;
    bus.vissue_en_i   = 1'b0;
    bus.vissue_addr_i = '0;
    for (int i = 0; i < 32; i++) modelRegs[i] = '0;
    modelBusy = '0;

    // Power-up reset brings DUT state out of X before any checking.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Write v5, then read it on port 2.
    applyStimulus(1'b1, 5'd5, {8{32'hDEADBEEF}}, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd5, 1'b0, 5'd0);
    checkOutput("v5_const", bus.vrs2_data_o, {8{32'hDEADBEEF}});

    // Same-cycle write and read of v7 (previously 0).
    applyStimulus(1'b1, 5'd7, 256'h1, 1'b1, 5'd7, 5'd5, 1'b0, 5'd0);
`ifdef V_REGFILE_BYPASS_EN
    checkOutput("collide_const", bus.vrs1_data_o, 256'h1);
`else
    checkOutput("collide_const", bus.vrs1_data_o, 256'h0);
`endif

    // Scoreboard: claim v3, observe busy, re-issue stalls, writeback frees.
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0);
    checkOutput("busy3_const", 256'(bus.vrs1_busy_o), 256'd1);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd3, 5'd0, 1'b1, 5'd3);
    checkOutput("stall3_const", 256'(bus.vstall_o), 256'd1);
    checkOutput("busy3_kept", 256'(bus.vrs1_busy_o), 256'd1);
    applyStimulus(1'b1, 5'd3, 256'h33, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0);
    checkOutput("busy3_clear", 256'(bus.vrs1_busy_o), 256'd0);

    // Simultaneous writeback and issue on the same busy register.
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9);
    applyStimulus(1'b1, 5'd9, 256'h99, 1'b0, 5'd9, 5'd0, 1'b1, 5'd9);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd9, 5'd0, 1'b0, 5'd0);
    checkOutput("busy9_owner", 256'(bus.vrs1_busy_o), 256'd1);

    // Writeback v9 while issuing v10.
    applyStimulus(1'b1, 5'd9, 256'h999, 1'b0, 5'd9, 5'd10, 1'b1, 5'd10);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd9, 5'd10, 1'b0, 5'd0);
    checkOutput("busy9_free", 256'(bus.vrs1_busy_o), 256'd0);
    checkOutput("busy10_set", 256'(bus.vrs2_busy_o), 256'd1);

    // Reset in the middle of traffic; the cycle's write/read/issue are dropped.
    rst = 1'b0;
    applyStimulus(1'b1, 5'd0, {8{32'hA5A5A5A5}}, 1'b1, 5'd9, 5'd5, 1'b1, 5'd12);
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd0, 5'd31, 1'b0, 5'd0);
    checkOutput("rst_rd1", bus.vrs1_data_o, 256'h0);
    checkOutput("rst_rd2", bus.vrs2_data_o, 256'h0);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd10, 5'd12, 1'b0, 5'd0);
    checkOutput("rst_busy10", 256'(bus.vrs1_busy_o), 256'd0);
    checkOutput("rst_busy12", 256'(bus.vrs2_busy_o), 256'd0);
    checkOutput("rst_stall", 256'(bus.vstall_o), 256'd0);

    // Back-to-back writes to v1..v31, then read every register back.
    for (int i = 1; i < 32; i++) begin
      for (int w = 0; w < 8; w++) rdata[w*32 +: 32] = $urandom;
      applyStimulus(1'b1, 5'(i), rdata, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
